// File: rtl/multdiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_unit : iterative signed 32-bit Booth multiplier / restoring divider |
// | Optional divider datapath: define MULTDIV_DIV_EN to build it.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);
   localparam logic [5:0] DONE_CNT  = 6'(WIDTH);

`ifdef MULTDIV_DIV_EN
   localparam state_t DIV_ENTRY = ST_DIV;
`else
   localparam state_t DIV_ENTRY = ST_DONE;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       cnt;
   logic [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             booth_q;
   logic [WIDTH:0]   opnd;
   logic             is_div;

   logic             start_mult;
   logic             start_div;
   logic [WIDTH:0]   booth_sum;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]   prod_top;
   logic             mult_ovf;
   logic [WIDTH-1:0] fin_result;
   logic             fin_exc;

   assign start_mult = ctrl_MULT;
   assign start_div  = ctrl_DIV & ~ctrl_MULT;

   // Booth step on a 33-bit upper half so subtracting the most negative multiplicand cannot wrap
   always_comb begin
      booth_sum = acc_hi;
      case ({acc_lo[0], booth_q})
         2'b01:   booth_sum = acc_hi + opnd;
         2'b10:   booth_sum = acc_hi - opnd;
         default: booth_sum = acc_hi;
      endcase
   end

   assign product  = {acc_hi[WIDTH-1:0], acc_lo};
   assign prod_top = product[2*WIDTH-1:WIDTH-1];
   assign mult_ovf = !((&prod_top) || (prod_top == '0));

`ifdef MULTDIV_DIV_EN
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_fits;
   logic             neg_q;
   logic             div_zero;
   logic             div_ovf;

   assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   // Partial remainder lives in acc_hi, dividend/quotient bits shift through acc_lo
   assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {1'b0, opnd};
   assign div_fits  = ~div_diff[WIDTH+1];
`endif

   always_comb begin
      fin_result = product[WIDTH-1:0];
      fin_exc    = mult_ovf;
      if (is_div) begin
`ifdef MULTDIV_DIV_EN
         if (div_zero) begin
            fin_result = '0;
            fin_exc    = 1'b1;
         end else begin
            fin_result = neg_q ? -acc_lo : acc_lo;
            fin_exc    = div_ovf;
         end
`else
         fin_result = '0;
         fin_exc    = 1'b1;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start_mult) begin
         state_nxt = ST_MULT;
      end else if (start_div) begin
         state_nxt = DIV_ENTRY;
      end else begin
         case (state)
            ST_MULT, ST_DIV: if (cnt == LAST_ITER) state_nxt = ST_DONE;
            ST_DONE:         if (cnt == DONE_CNT)  state_nxt = ST_IDLE;
            default:         state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt            <= '0;
         acc_hi         <= '0;
         acc_lo         <= '0;
         booth_q        <= 1'b0;
         opnd           <= '0;
         is_div         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
`endif
      end else begin
         data_resultRDY <= 1'b0;
         if (start_mult) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= data_operandB;
            booth_q <= 1'b0;
            opnd    <= {data_operandA[WIDTH-1], data_operandA};
            is_div  <= 1'b0;
         end else if (start_div) begin
            cnt    <= '0;
            is_div <= 1'b1;
`ifdef MULTDIV_DIV_EN
            acc_hi   <= '0;
            acc_lo   <= abs_a;
            opnd     <= {1'b0, abs_b};
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
`endif
         end else begin
            case (state)
               ST_MULT: begin
                  acc_hi  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                  acc_lo  <= {booth_sum[0], acc_lo[WIDTH-1:1]};
                  booth_q <= acc_lo[0];
                  cnt     <= cnt + 6'd1;
               end
`ifdef MULTDIV_DIV_EN
               ST_DIV: begin
                  acc_hi <= div_fits ? div_diff[WIDTH:0] : div_shift;
                  acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
                  cnt    <= cnt + 6'd1;
               end
`endif
               ST_DONE: begin
                  // A direct entry with a cleared counter spends one extra cycle here
                  if (cnt == DONE_CNT) begin
                     data_result    <= fin_result;
                     data_exception <= fin_exc;
                     data_resultRDY <= 1'b1;
                  end else begin
                     cnt <= DONE_CNT;
                  end
               end
               default: cnt <= cnt;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for multdiv_unit: stimulus pushes expected results, a monitor checks each RDY.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int unsigned due;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          fails = 0;
   int          rdy_cnt = 0;

`ifdef MULTDIV_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   multdiv_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %08h, required %08h", nm, act, req);
      end
   endtask

   // Monitor: every RDY pulse must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         rdy_cnt++;
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rdy: got RDY at cycle %0d, required none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_result"}, data_result, e.res);
            chk({e.nm, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
            chk({e.nm, "_latency"}, cyc, e.due);
         end
      end
   end

   // Start pulse lands on the next rising edge; expected RDY is seen lat cycles after it
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] er, input logic ee, input int lat,
                        input string nm);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = m;
      ctrl_DIV = d;
      if (push) sb.push_back('{er, ee, cyc + 1 + lat, nm});
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: got %0d pending, required 0", nm, sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic div_case(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                           input logic ee, input string nm);
      if (DIV_ON) issue(1'b0, 1'b1, a, b, 1'b1, er, ee, 33, nm);
      else        issue(1'b0, 1'b1, a, b, 1'b1, 32'h0, 1'b1, 2, nm);
      drain(nm);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clock);
      chk("reset_result", data_result, 32'h0);
      chk("reset_exception", {31'd0, data_exception}, 32'h0);
      chk("reset_rdy", {31'd0, data_resultRDY}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      issue(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 1'b0, 33, "mul_7xm3");
      drain("mul_7xm3");
      issue(1'b1, 1'b0, 32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 1'b1, 33, "mul_ovf_2p32");
      drain("mul_ovf_2p32");
      issue(1'b1, 1'b0, 32'h40000000, 32'h00000002, 1'b1, 32'h80000000, 1'b1, 33, "mul_ovf_2p31");
      drain("mul_ovf_2p31");
      issue(1'b1, 1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 33, "mul_min_x1");
      drain("mul_min_x1");

      // Back-to-back: second start sampled in the RDY cycle of the first
      issue(1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, 32'h0000001E, 1'b0, 33, "mul_m5xm6");
      repeat (32) @(negedge clock);
      issue(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h00000001, 1'b1, 33, "mul_max_sq");
      drain("mul_max_sq");
      issue(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, 33, "mul_min_xm1");
      drain("mul_min_xm1");

      div_case(32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_m7_2");
      div_case(32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_m7");
      div_case(32'h00001234, 32'h00000000, 32'h00000000, 1'b1, "div_by_zero");
      div_case(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_m1");
      issue(1'b1, 1'b0, 32'h00000009, 32'h0000000B, 1'b1, 32'h00000063, 1'b0, 33, "mul_after_div");
      drain("mul_after_div");

      // Abort: the multiply is replaced by a divide started ten cycles later
      issue(1'b1, 1'b0, 32'd3, 32'd5, 1'b0, 32'h0, 1'b0, 0, "aborted_mul");
      repeat (8) @(negedge clock);
      if (DIV_ON) issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'h0000000E, 1'b0, 33, "abort_div");
      else        issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'h00000000, 1'b1, 2, "abort_div");
      drain("abort_div");
      issue(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, 32'h00000012, 1'b0, 33, "both_starts");
      drain("both_starts");

      // Reset at cycle 15 of a multiply, with a start pulse that must be ignored
      issue(1'b1, 1'b0, 32'h00001234, 32'h00000010, 1'b0, 32'h0, 1'b0, 0, "reset_victim");
      repeat (13) @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd4;
      data_operandB = 32'd4;
      @(negedge clock);
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      chk("midreset_result", data_result, 32'h0);
      chk("midreset_exception", {31'd0, data_exception}, 32'h0);
      chk("midreset_rdy", {31'd0, data_resultRDY}, 32'h0);
      base = rdy_cnt;
      repeat (40) @(negedge clock);
      chk("midreset_no_rdy", rdy_cnt - base, 32'h0);
      issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'h00000006, 1'b0, 33, "mul_after_reset");
      drain("mul_after_reset");

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
